// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream and memory-write bundle for imem_loader
//
// Purpose: groups the loader's two handshake/bus paths into a single port.
//   Byte stream (valid/ready):
//     byte_valid  upstream -> loader   byte_in carries a byte this cycle
//     byte_in     upstream -> loader   8-bit stream byte
//     byte_ready  loader -> upstream   loader can accept a byte this cycle
//   Instruction-memory write port:
//     mem_wEn     loader -> memory     write enable, one cycle per word
//     mem_addr    loader -> memory     word address, ADDRESS_WIDTH bits
//     mem_dataIn  loader -> memory     write data, DATA_WIDTH bits
// Modports: master = the loader, slave = the byte source / memory side.

interface imem_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);

  logic                     byte_valid;
  logic [7:0]               byte_in;
  logic                     byte_ready;
  logic                     mem_wEn;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_dataIn;

  modport master (
    input  byte_valid,
    input  byte_in,
    output byte_ready,
    output mem_wEn,
    output mem_addr,
    output mem_dataIn
  );

  modport slave (
    output byte_valid,
    output byte_in,
    input  byte_ready,
    input  mem_wEn,
    input  mem_addr,
    input  mem_dataIn
  );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream instruction-memory loader
//
// Purpose: receives a 2-byte little-endian word count N followed by N*4
// little-endian data bytes, and writes the assembled words to instruction
// memory from address 0 upward while holding the CPU.
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high
//   start         single-cycle pulse arming a load (honoured in IDLE/DONE/ERR)
//   bus           imem_loader_if.master: byte stream in, memory write port out
//   cpu_hold      high while a load is in progress or after a bad header
//   done          level, last load completed successfully
//   error         level, last load aborted on a bad length
//   words_loaded  words written in the current or last load

module imem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  imem_loader_if.master          bus,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error,
  output logic [ADDRESS_WIDTH:0] words_loaded
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // Header lengths are compared in 17 bits so DEPTH=65536 would still fit.
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [15:0]              len;
  logic [1:0]               byte_idx;
  // Lanes 0..2 of the word being assembled; lane 3 arrives with the write.
  logic [23:0]              word_buf;
  logic                     mem_wen_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_data_q;

  logic                     byte_ready_c;
  logic                     accept;
  logic [15:0]              hdr_len;
  logic                     len_bad;
  logic                     last_word;
  logic                     hold_nxt;

  assign byte_ready_c = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                        (state == ST_DATA);
  assign accept       = bus.byte_valid && byte_ready_c;

  // Full length as it would be once the high byte in flight is captured.
  assign hdr_len   = {bus.byte_in, len[7:0]};
  assign len_bad   = (hdr_len == 16'd0) || (17'(hdr_len) > DEPTH_LIM);

  // Evaluated in WRITE, before words_loaded counts the word being written.
  assign last_word = (17'(words_loaded) + 17'd1) == 17'(len);

  assign bus.byte_ready = byte_ready_c;
  assign bus.mem_wEn    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_dataIn = mem_data_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_nxt = len_bad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (accept && (byte_idx == 2'd3)) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = last_word ? ST_DONE : ST_DATA;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The CPU is released only when idle or after a successful load; a bad
  // header keeps it held so it never runs a partially loaded image.
  assign hold_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state     <= state_nxt;
      // Status outputs are registered from the next state so they change on
      // the same edge as the state itself.
      mem_wen_q <= (state_nxt == ST_WRITE);
      cpu_hold  <= hold_nxt;
      done      <= (state_nxt == ST_DONE);
      error     <= (state_nxt == ST_ERR);

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) words_loaded <= '0;
        end
        ST_LEN_LO: begin
          if (accept) len[7:0] <= bus.byte_in;
        end
        ST_LEN_HI: begin
          if (accept) begin
            len[15:8]  <= bus.byte_in;
            mem_addr_q <= '0;
            byte_idx   <= '0;
          end
        end
        ST_DATA: begin
          if (accept) begin
            case (byte_idx)
              2'd0:    word_buf[7:0]   <= bus.byte_in;
              2'd1:    word_buf[15:8]  <= bus.byte_in;
              2'd2:    word_buf[23:16] <= bus.byte_in;
              default: mem_data_q      <= {bus.byte_in, word_buf};
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_WRITE: begin
          words_loaded <= words_loaded + (ADDRESS_WIDTH+1)'(1);
          // Address advances only when another word follows, so it stops
          // at len-1 and can never wrap.
          if (!last_word) mem_addr_q <= mem_addr_q + ADDRESS_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the instruction-memory block.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles the bytes into little-endian DATA_WIDTH words and drives the memory write port (wEn/addr/dataIn) sequentially from address 0.
- Holds the CPU via cpu_hold while a load is in progress, and reports completion or error.

Parameters:
- DATA_WIDTH, 32, word width written to memory; fixed at 32 (4 bytes per word).
- ADDRESS_WIDTH, 12, memory address width.
- DEPTH, 4096, number of memory words; maximum legal load length.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that arms a load.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_in  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_wEn  output  1  memory write enable.
- mem_addr  output  ADDRESS_WIDTH  memory write address.
- mem_dataIn  output  DATA_WIDTH  memory write data.
- cpu_hold  output  1  keeps the processor stalled/in reset while high.
- done  output  1  level; last load completed successfully.
- error  output  1  level; last load aborted on a bad length.
- words_loaded  output  ADDRESS_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - state=IDLE.
  - byte_ready=0, mem_wEn=0, mem_addr=0, mem_dataIn=0.
  - cpu_hold=0, done=0, error=0, words_loaded=0.
  - Internal length register=0, byte index=0.
- Handshake:
  - A byte is accepted on a cycle with byte_valid && byte_ready.
  - byte_ready is a combinational function of state: 1 in LEN_LO, LEN_HI and DATA; 0 otherwise.
  - byte_in is ignored when no byte is accepted.
- Stream format:
  - 2-byte little-endian word count N, then N*4 data bytes.
  - Each word is little-endian: the first byte goes to [7:0], the fourth to [31:24].
- States:
  - IDLE: start -> LEN_LO; also clears done, error and words_loaded.
  - LEN_LO: accepted byte -> len[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte -> len[15:8].
    - If {byte,len[7:0]} == 0 or > DEPTH -> ERR.
    - Otherwise -> DATA, with mem_addr=0 and byte index=0.
  - DATA: each accepted byte goes into lane [byte_idx]; byte_idx increments.
    - Accepting the byte with byte_idx==3 -> WRITE, and byte_idx wraps to 0.
  - WRITE: mem_wEn=1 for exactly one cycle, with mem_addr and the assembled mem_dataIn stable.
    - byte_ready=0 in this state.
    - On the next cycle: words_loaded increments.
    - If words_loaded+1 == len -> DONE; else mem_addr increments and the block returns to DATA.
  - DONE: done=1, cpu_hold=0. start -> LEN_LO (re-arm).
  - ERR: error=1, cpu_hold=1, no memory writes. start -> LEN_LO.
- cpu_hold:
  - 1 in LEN_LO, LEN_HI, DATA, WRITE and ERR.
  - 0 in IDLE and DONE.
  - Registered: it changes on the cycle the state changes.
- Latency: fourth byte of a word accepted at cycle t -> mem_wEn high at cycle t+1.
- Minimum cost is 5 cycles per word (4 byte cycles plus 1 WRITE cycle).
- start is ignored in every state except IDLE, DONE and ERR.
- mem_addr never wraps.
  - The maximum address written is len-1, which is at most DEPTH-1.
  - words_loaded reaches DEPTH without overflow, which is why it has the extra bit.
- Reset asserted mid-load:
  - The block returns to the reset values on the next edge; no further writes occur.
  - Words already written remain in memory.
- byte_valid stalls (gaps) of any length are legal. State and partial-word contents hold until the next accepted byte.
- mem_dataIn holds its last value when mem_wEn=0.

Test Plan:
- Reset for 2 cycles -> all outputs 0 and byte_ready=0. byte_valid=1 in IDLE -> nothing accepted.
- Pulse start; send 02 00 78 56 34 12 EF BE AD DE back-to-back:
  - Two writes occur: addr0=0x12345678, then addr1=0xDEADBEEF.
  - mem_wEn is high exactly 1 cycle after the 4th and 8th data bytes.
  - Afterwards done=1, words_loaded=2, and cpu_hold falls.
- Same load with random 0-5 cycle byte_valid gaps, plus a start pulse mid-load:
  - Identical writes and final state as the back-to-back load.
  - The mid-load start has no effect.
- Header 00 00 -> error=1, cpu_hold=1, no mem_wEn.
- Header 01 10 (4097) -> error=1, cpu_hold=1, no mem_wEn.
- After either error, pulse start and send a valid 1-word load -> error clears, done=1.
- Reset after 3 data bytes of word 0 -> IDLE on the next cycle, no write ever issued, all outputs at reset values.
- Header 00 10 (N=DEPTH) followed by 16384 bytes:
  - The last write is at addr 4095.
  - words_loaded=4096 and done=1.
  - No write to addr 0 after the first one.
